// File: rtl/add_hold_queue.sv
// Purpose : DEPTH-entry FIFO holding ALU results (data + carry + overflow) for ordered
//           multi-byte address arithmetic, with tri-state drive onto ADL and split SB.
// Latency : a pushed entry is visible at the head one phi2 edge later.
//           Bus drive follows its enable combinationally.
// Backpr. : no handshake. Push while full (without pop) drops the data and sets a sticky
//           ovf_ERR. Pop while empty is ignored.
//
// Ports:
//   phi2, rst_N                  clock (rising edge) / async active-low reset
//   alu_OUT, alu_C, alu_V        ALU result captured at tail on push_EN
//   push_EN, pop_EN, clear_EN    queue control (clear has priority over push/pop)
//   adl_EN, sbLo_EN, sbHi_EN     independent tri-state enables for ADL, SB[W-2:0], SB[W-1]
//   addressLowBus, systemBus     tri-state buses
//   hold_C, hold_V               flags of the head entry (0 when empty)
//   count, empty, full, ovf_ERR  occupancy and sticky overflow status
//
// Build option: define ADD_HOLD_SB_BYPASS_EN to source SB from the live alu_OUT
// instead of the head entry. ADL always uses the head entry.
module add_hold_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       phi2,
    input  logic                       rst_N,
    input  logic [WIDTH-1:0]           alu_OUT,
    input  logic                       alu_C,
    input  logic                       alu_V,
    input  logic                       push_EN,
    input  logic                       pop_EN,
    input  logic                       clear_EN,
    input  logic                       adl_EN,
    input  logic                       sbLo_EN,
    input  logic                       sbHi_EN,
    output logic [WIDTH-1:0]           addressLowBus,
    output logic [WIDTH-1:0]           systemBus,
    output logic                       hold_C,
    output logic                       hold_V,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf_ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             c;
        logic             v;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            do_push, do_pop;
    entry_t          head;
    logic [WIDTH-1:0] sb_src;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A pop frees the slot in the same edge, so push+pop while full still succeeds.
    assign do_pop  = pop_EN && !empty;
    assign do_push = push_EN && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear_EN) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = '{dat: alu_OUT, c: alu_C, v: alu_V};
                // DEPTH is a power of two, so the pointer wraps naturally.
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (push_EN && !do_push) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge phi2 or negedge rst_N) begin
        if (!rst_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Stale storage behind rd_ptr must not leak out when the queue is empty.
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign hold_C  = head.c;
    assign hold_V  = head.v;
    assign count   = count_q;
    assign ovf_ERR = ovf_q;

`ifdef ADD_HOLD_SB_BYPASS_EN
    assign sb_src = alu_OUT;
`else
    assign sb_src = head.dat;
`endif

    assign addressLowBus           = adl_EN  ? head.dat             : {WIDTH{1'bz}};
    assign systemBus[WIDTH-2:0]    = sbLo_EN ? sb_src[WIDTH-2:0]    : {(WIDTH-1){1'bz}};
    // MSB has its own enable so a right shift can fill it from elsewhere.
    assign systemBus[WIDTH-1]      = sbHi_EN ? sb_src[WIDTH-1]      : 1'bz;

endmodule

// File: tb/tb_add_hold_queue.sv
module tb_add_hold_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             phi2;
    logic             rst_N;
    logic [WIDTH-1:0] alu_OUT;
    logic             alu_C, alu_V;
    logic             push_EN, pop_EN, clear_EN;
    logic             adl_EN, sbLo_EN, sbHi_EN;
    wire  [WIDTH-1:0] addressLowBus;
    wire  [WIDTH-1:0] systemBus;
    logic             hold_C, hold_V;
    logic [1:0]       count;
    logic             empty, full, ovf_ERR;

    int n_cmp = 0;
    int n_err = 0;

    add_hold_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .phi2(phi2), .rst_N(rst_N),
        .alu_OUT(alu_OUT), .alu_C(alu_C), .alu_V(alu_V),
        .push_EN(push_EN), .pop_EN(pop_EN), .clear_EN(clear_EN),
        .adl_EN(adl_EN), .sbLo_EN(sbLo_EN), .sbHi_EN(sbHi_EN),
        .addressLowBus(addressLowBus), .systemBus(systemBus),
        .hold_C(hold_C), .hold_V(hold_V),
        .count(count), .empty(empty), .full(full), .ovf_ERR(ovf_ERR)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a plain queue of {data,C,V} ----------------
    logic [WIDTH+1:0] mq[$];
    bit               m_ovf;

    always @(posedge phi2 or negedge rst_N) begin
        if (!rst_N) begin
            mq.delete();
            m_ovf = 0;
        end else if (clear_EN) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            bit pop_ok;
            pop_ok = pop_EN && (mq.size() > 0);
            if (push_EN && !pop_ok && mq.size() == DEPTH) begin
                m_ovf = 1;
            end else begin
                if (pop_ok) void'(mq.pop_front());
                if (push_EN) mq.push_back({alu_OUT, alu_C, alu_V});
            end
        end
    end

    // Compare every cycle on the falling edge, only bits whose enable is high on the buses.
    always @(negedge phi2) begin
        logic [WIDTH+1:0] h;
        logic [WIDTH-1:0] src, adl_m, sb_m;
        h = (mq.size() > 0) ? mq[0] : '0;
`ifdef ADD_HOLD_SB_BYPASS_EN
        src = alu_OUT;
`else
        src = h[WIDTH+1:2];
`endif
        adl_m = {WIDTH{adl_EN}};
        sb_m  = {sbHi_EN, {(WIDTH-1){sbLo_EN}}};
        chk("m_count", 16'(count), 16'(mq.size()));
        chk("m_empty", 16'(empty), 16'(mq.size() == 0));
        chk("m_full",  16'(full),  16'(mq.size() == DEPTH));
        chk("m_ovf",   16'(ovf_ERR), 16'(m_ovf));
        chk("m_hold_C", 16'(hold_C), 16'(h[1]));
        chk("m_hold_V", 16'(hold_V), 16'(h[0]));
        chk("m_adl", 16'(addressLowBus & adl_m), 16'(h[WIDTH+1:2] & adl_m));
        chk("m_sb",  16'(systemBus & sb_m), 16'(src & sb_m));
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input bit push, input bit pop, input bit clr,
                        input logic [7:0] d, input bit c, input bit v);
        push_EN = push; pop_EN = pop; clear_EN = clr;
        alu_OUT = d; alu_C = c; alu_V = v;
        @(posedge phi2); #1;
        push_EN = 0; pop_EN = 0; clear_EN = 0;
    endtask

    initial begin
        rst_N = 0;
        push_EN = 0; pop_EN = 0; clear_EN = 0;
        alu_OUT = 8'h00; alu_C = 0; alu_V = 0;
        adl_EN = 1; sbLo_EN = 1; sbHi_EN = 1;

        // 1: reset state with all enables on
        #2;
        chk("rst_adl", 16'(addressLowBus), 16'h00);
        chk("rst_sb", 16'(systemBus), 16'h00);
        chk("rst_empty", 16'(empty), 16'h1);
        chk("rst_full", 16'(full), 16'h0);
        chk("rst_count", 16'(count), 16'h0);
        chk("rst_ovf", 16'(ovf_ERR), 16'h0);
        @(negedge phi2); rst_N = 1;
        @(posedge phi2); #1;

        // 2: two pushes then pop
        step(1, 0, 0, 8'h34, 1, 0);
        chk("t2_count1", 16'(count), 16'h1);
        step(1, 0, 0, 8'h12, 0, 1);
        chk("t2_count2", 16'(count), 16'h2);
        chk("t2_full", 16'(full), 16'h1);
        chk("t2_adl", 16'(addressLowBus), 16'h34);
        chk("t2_holdc", 16'(hold_C), 16'h1);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("t2_adl_pop", 16'(addressLowBus), 16'h12);
        chk("t2_holdc_pop", 16'(hold_C), 16'h0);
        chk("t2_holdv_pop", 16'(hold_V), 16'h1);

        // 3: overflow while full, then clear
        step(1, 0, 0, 8'h56, 0, 0);
        step(1, 0, 0, 8'h99, 1, 1);
        chk("t3_ovf", 16'(ovf_ERR), 16'h1);
        chk("t3_adl", 16'(addressLowBus), 16'h12);
        chk("t3_count", 16'(count), 16'h2);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("t3_second", 16'(addressLowBus), 16'h56);
        step(1, 1, 1, 8'h77, 0, 0);   // clear overrides push+pop
        chk("t3_clr_count", 16'(count), 16'h0);
        chk("t3_clr_ovf", 16'(ovf_ERR), 16'h0);
        chk("t3_clr_adl", 16'(addressLowBus), 16'h00);

        // pop on empty ignored; push+pop on empty keeps only the push
        step(0, 1, 0, 8'h00, 0, 0);
        chk("e_pop_count", 16'(count), 16'h0);
        chk("e_pop_ovf", 16'(ovf_ERR), 16'h0);
        step(1, 1, 0, 8'h5A, 0, 1);
        chk("e_pp_count", 16'(count), 16'h1);
        chk("e_pp_adl", 16'(addressLowBus), 16'h5A);
        step(0, 1, 0, 8'h00, 0, 0);

        // 4: full, push+pop on the same edge, pointers wrap
        step(1, 0, 0, 8'hA1, 0, 0);
        step(1, 0, 0, 8'hB2, 0, 0);
        step(1, 1, 0, 8'hC3, 1, 0);
        chk("t4_count", 16'(count), 16'h2);
        chk("t4_full", 16'(full), 16'h1);
        chk("t4_head1", 16'(addressLowBus), 16'hB2);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("t4_head2", 16'(addressLowBus), 16'hC3);
        chk("t4_holdc", 16'(hold_C), 16'h1);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("t4_empty", 16'(empty), 16'h1);

        // 5: split SB enables
        step(1, 0, 0, 8'hFF, 0, 0);
        sbHi_EN = 0;
        #1;
        chk("t5_sblo", 16'(systemBus[6:0]), 16'h7F);
        alu_OUT = 8'h80; sbHi_EN = 1;
        #1;
`ifdef ADD_HOLD_SB_BYPASS_EN
        chk("t5_sb_bypass", 16'(systemBus), 16'h80);
`else
        chk("t5_sb_head", 16'(systemBus), 16'hFF);
`endif
        chk("t5_adl", 16'(addressLowBus), 16'hFF);
        adl_EN = 0; #1;
        adl_EN = 1;

        // 6: async reset between edges with one entry held
        @(posedge phi2); #2;
        rst_N = 0;
        #1;
        chk("t6_empty", 16'(empty), 16'h1);
        chk("t6_count", 16'(count), 16'h0);
        chk("t6_adl", 16'(addressLowBus), 16'h00);
        @(negedge phi2); rst_N = 1;
        repeat (3) @(posedge phi2);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
